// File: rtl/regfile_seq_ctrl_if.sv
// Command handshake between the front end (or a test master) and the
// register-file sequencer. One command transfers per cycle with valid and ready both high.
interface regfile_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for an 8x8 register file. Runs each accepted command
// through READ -> EXEC -> WRITE, one cycle per state. All outputs are registered.
// rf_regwrite_n is driven from a flop, so it cannot glitch low.
module regfile_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    regfile_seq_ctrl_if.slave cmd,
    output logic [ADDR_W-1:0] rf_read_addr_1,
    output logic [ADDR_W-1:0] rf_read_addr_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regwrite_n,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_MOV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              carry_q;
    logic [DATA_W:0]   exec_res;

    // Result is one bit wider than the data path. The top bit is the ADD carry-out or the SUB borrow.
    function automatic logic [DATA_W:0] exec_result(
        input op_t               op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W:0] r;
        case (op)
            OP_LOADI: r = {1'b0, imm};
            OP_ADD:   r = {1'b0, a} + {1'b0, b};
            OP_SUB:   r = {1'b0, a} - {1'b0, b};
            default:  r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign exec_res = exec_result(op_q, a_q, b_q, imm_q);

    // Sequencer FSM with registered outputs. Reset aborts any command at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cmd.cmd_ready  <= 1'b1;
            op_q           <= OP_LOADI;
            rd_q           <= '0;
            imm_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            carry_q        <= 1'b0;
            rf_read_addr_1 <= '0;
            rf_read_addr_2 <= '0;
            rf_write_addr  <= '0;
            rf_write_data  <= '0;
            rf_regwrite_n  <= 1'b1;
            done           <= 1'b0;
            flag_z         <= 1'b0;
            flag_c         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q           <= op_t'(cmd.cmd_op);
                        rd_q           <= cmd.cmd_rd;
                        imm_q          <= cmd.cmd_imm;
                        rf_read_addr_1 <= cmd.cmd_rs1;
                        rf_read_addr_2 <= cmd.cmd_rs2;
                        cmd.cmd_ready  <= 1'b0;
                        state          <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Register file reads are combinational, so the operands are valid by the end of READ.
                    a_q   <= rf_read_data_1;
                    b_q   <= rf_read_data_2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    rf_write_addr <= rd_q;
                    rf_write_data <= exec_res[DATA_W-1:0];
                    carry_q       <= exec_res[DATA_W];
                    rf_regwrite_n <= 1'b0;
                    done          <= 1'b1;
                    state         <= ST_WRITE;
                end
                ST_WRITE: begin
                    // The write commits on this edge. The flags update on the same edge.
                    rf_regwrite_n <= 1'b1;
                    done          <= 1'b0;
                    flag_z        <= (rf_write_data == '0);
                    flag_c        <= carry_q;
                    cmd.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    rf_regwrite_n <= 1'b1;
                    done          <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl. It contains a behavioural 8x8 register file.
// A scoreboard is filled from an arithmetic reference model when each command is issued.
// A monitor drains the scoreboard on every done pulse.
module tb_regfile_seq_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_seq_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cmd ();

    logic [ADDR_W-1:0] rf_read_addr_1, rf_read_addr_2, rf_write_addr;
    logic [DATA_W-1:0] rf_read_data_1, rf_read_data_2, rf_write_data;
    logic              rf_regwrite_n, done, flag_z, flag_c;

    regfile_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd.slave),
        .rf_read_addr_1 (rf_read_addr_1),
        .rf_read_addr_2 (rf_read_addr_2),
        .rf_read_data_1 (rf_read_data_1),
        .rf_read_data_2 (rf_read_data_2),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_regwrite_n  (rf_regwrite_n),
        .done           (done),
        .flag_z         (flag_z),
        .flag_c         (flag_c)
    );

    // Register file: combinational reads, write on the clock edge while the strobe is low, async clear.
    logic [DATA_W-1:0] rf_mem [8];
    assign rf_read_data_1 = rf_mem[rf_read_addr_1];
    assign rf_read_data_2 = rf_mem[rf_read_addr_2];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
        end else if (!rf_regwrite_n) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents, updated command by command.
    typedef struct {
        int addr;
        int data;
        int z;
        int c;
    } exp_t;
    exp_t sb[$];
    int   ref_regs [8];

    task automatic model_cmd(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int a, b, r, c;
        exp_t e;
        a = ref_regs[rs1];
        b = ref_regs[rs2];
        c = 0;
        case (op)
            0: r = imm;
            1: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            2: begin r = a - b; c = (a < b) ? 1 : 0; r = (r + 256) % 256; end
            default: r = a;
        endcase
        ref_regs[rd] = r;
        e.addr = rd;
        e.data = r;
        e.z = (r == 0) ? 1 : 0;
        e.c = c;
        sb.push_back(e);
    endtask

    // Monitor: checks each write-back against the scoreboard, then checks the flags one cycle later.
    int done_cnt = 0;
    int wr_cnt = 0;
    int done_cyc[$];
    bit flag_chk = 0;
    int exp_z, exp_c;
    always @(negedge clk) begin
        exp_t e;
        if (flag_chk) begin
            check("flag_z", int'(flag_z), exp_z);
            check("flag_c", int'(flag_c), exp_c);
            flag_chk = 0;
        end
        if (!rf_regwrite_n) begin
            wr_cnt++;
            check("done_with_strobe", int'(done), 1);
        end
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", int'(rf_write_addr), e.addr);
                check("wr_data", int'(rf_write_data), e.data);
                exp_z = e.z;
                exp_c = e.c;
                flag_chk = 1;
            end
        end
    end

    logic [1:0] op_v;
    logic [2:0] rd_v, rs1_v, rs2_v;
    logic [7:0] imm_v;

    // Caller is at a negedge. Waits for ready, issues one command, then follows it to completion.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int n;
        n = 0;
        while (!cmd.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd.cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        op_v = 2'(op); rd_v = 3'(rd); rs1_v = 3'(rs1); rs2_v = 3'(rs2); imm_v = 8'(imm);
        cmd.cmd_op = op_v; cmd.cmd_rd = rd_v; cmd.cmd_rs1 = rs1_v;
        cmd.cmd_rs2 = rs2_v; cmd.cmd_imm = imm_v;
        cmd.cmd_valid = 1'b1;
        model_cmd(op, rd, rs1, rs2, imm);
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op = 2'($urandom); cmd.cmd_rd = 3'($urandom); cmd.cmd_rs1 = 3'($urandom);
        cmd.cmd_rs2 = 3'($urandom); cmd.cmd_imm = 8'($urandom);
        check("ready_in_read", int'(cmd.cmd_ready), 0);
        @(negedge clk);
        check("ready_in_exec", int'(cmd.cmd_ready), 0);
        check("strobe_in_exec", int'(rf_regwrite_n), 1);
        @(negedge clk);
        check("strobe_in_write", int'(rf_regwrite_n), 0);
        @(negedge clk);
        check("ready_after_write", int'(cmd.cmd_ready), 1);
    endtask

    initial begin
        int d0, w0, rc, n;
        cmd.cmd_valid = 1'b0; cmd.cmd_op = '0; cmd.cmd_rd = '0;
        cmd.cmd_rs1 = '0; cmd.cmd_rs2 = '0; cmd.cmd_imm = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(cmd.cmd_ready), 1);
        check("rst_strobe", int'(rf_regwrite_n), 1);
        check("rst_done", int'(done), 0);
        check("rst_flags", int'({flag_z, flag_c}), 0);
        check("rst_addrs", int'({rf_read_addr_1, rf_read_addr_2, rf_write_addr}), 0);
        check("rst_wdata", int'(rf_write_data), 0);
        reset = 1'b1;
        @(negedge clk);

        // LOADI then a dependent MOV; done pulses are 4 cycles apart.
        d0 = done_cyc.size();
        issue(0, 3, 0, 0, 8'h5A);
        issue(3, 5, 3, 0, 0);
        if (done_cyc.size() >= d0 + 2) check("done_spacing", done_cyc[d0+1] - done_cyc[d0], 4);
        else check("done_pulses", done_cyc.size() - d0, 2);
        check("r5_mov", int'(rf_mem[5]), 8'h5A);
        check("r3_kept", int'(rf_mem[3]), 8'h5A);

        // ADD with carry-out.
        issue(0, 1, 0, 0, 8'hF0);
        issue(0, 2, 0, 0, 8'h20);
        issue(1, 4, 1, 2, 0);
        check("r4_add", int'(rf_mem[4]), 8'h10);
        check("add_c", int'(flag_c), 1);
        check("add_z", int'(flag_z), 0);

        // SUB to zero with rs1 = rs2, then SUB with borrow.
        issue(0, 6, 0, 0, 8'h33);
        issue(2, 7, 6, 6, 0);
        check("r7_sub", int'(rf_mem[7]), 0);
        check("sub_z", int'(flag_z), 1);
        check("sub_c", int'(flag_c), 0);
        issue(0, 0, 0, 0, 8'h01);
        issue(2, 2, 7, 0, 0);
        check("sub_borrow_val", int'(rf_mem[2]), 8'hFF);
        check("sub_borrow_c", int'(flag_c), 1);

        // Dependent chain on r1 with rd = rs1 = rs2.
        d0 = done_cnt;
        issue(0, 1, 0, 0, 8'h03);
        for (int k = 0; k < 4; k++) issue(1, 1, 1, 1, 0);
        check("chain_r1", int'(rf_mem[1]), 8'h30);
        check("chain_done_cnt", done_cnt - d0, 5);

        // cmd_valid held high for 12 cycles with one LOADI.
        d0 = done_cyc.size(); w0 = wr_cnt; rc = 0;
        for (int k = 0; k < 3; k++) model_cmd(0, 6, 0, 0, 8'h77);
        cmd.cmd_op = 2'b00; cmd.cmd_rd = 3'd6; cmd.cmd_imm = 8'h77; cmd.cmd_valid = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (cmd.cmd_ready) rc++;
        end
        cmd.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_ready_cycles", rc, 3);
        check("hold_writes", wr_cnt - w0, 3);
        check("hold_dones", done_cyc.size() - d0, 3);
        if (done_cyc.size() >= d0 + 3) begin
            check("hold_spacing_a", done_cyc[d0+1] - done_cyc[d0], 4);
            check("hold_spacing_b", done_cyc[d0+2] - done_cyc[d0+1], 4);
        end

        // Randomized commands against the reference model.
        for (int k = 0; k < 60; k++)
            issue(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(7)), int'($urandom_range(255)));
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);
        for (int i = 0; i < 8; i++) check($sformatf("final_r%0d", i), int'(rf_mem[i]), ref_regs[i]);

        // Reset during EXEC: the command is discarded with no write.
        w0 = wr_cnt; d0 = done_cnt;
        cmd.cmd_op = 2'b01; cmd.cmd_rd = 3'd3; cmd.cmd_rs1 = 3'd1; cmd.cmd_rs2 = 3'd2;
        cmd.cmd_valid = 1'b1;
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_strobe", int'(rf_regwrite_n), 1);
        check("rstmid_ready", int'(cmd.cmd_ready), 1);
        check("rstmid_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        @(posedge clk);
        #1;
        check("rstrel_ready", int'(cmd.cmd_ready), 1);
        check("rstrel_flags", int'({flag_z, flag_c}), 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("rstmid_no_write", wr_cnt - w0, 0);
        check("rstmid_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), int'(rf_mem[i]), 0);

        // The sequencer works normally after the abort.
        issue(0, 4, 0, 0, 8'hC3);
        issue(1, 5, 4, 4, 0);
        repeat (2) @(negedge clk);
        check("post_rst_r5", int'(rf_mem[5]), 8'h86);
        check("post_rst_queue", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global cycle guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
